// File: rtl/ysyx_20020207_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_20020207_axi_rd_arbiter
//
// Two-master AXI4 read-channel arbiter. The IFU/icache (m0) and the LSU (m1)
// share one memory-side AR/R channel pair. Only one read transaction is in
// flight at a time. A grant is issued only in IDLE. Simultaneous requests are
// resolved round-robin against the master that finished last.
//
// Ports
//   clock, reset        : sole clock; asynchronous active-low reset
//   m{0,1}_ar*          : per-master read-address channel (valid/ready/addr/len)
//   m{0,1}_r*           : per-master read-data channel (valid/ready/data/resp/last)
//   s_ar*               : shared memory AR channel (size/burst are constants)
//   s_r*                : shared memory R channel
//   busy                : high while a transaction owns the shared channel
// ---------------------------------------------------------------------------
module ysyx_20020207_axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,

  // m0: IFU / icache
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,

  // m1: LSU
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,

  // shared memory AR channel
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,

  // shared memory R channel
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,

  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state;
  logic                owner;       // 0 = m0, 1 = m1
  logic                last_owner;  // master that completed most recently
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [7:0]          beat_cnt;    // informational only; rlast ends a burst

  logic                grant0;
  logic                grant1;
  logic                in_addr;
  logic                in_data;
  logic                own0;
  logic                own1;
  logic                beat_fire;

  // -------------------------------------------------------------------------
  // Grant decode. Combinational so the winning master sees arready in the
  // same cycle it raises arvalid. Gating with reset keeps both arready low
  // while reset is held, even though the state already reads IDLE. On a tie
  // the master that did not finish last wins; last_owner resets to 1 so m0
  // takes the first tie.
  // -------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && (state == ST_IDLE)) begin
      if (m0_arvalid && m1_arvalid) begin
        grant0 = last_owner;
        grant1 = !last_owner;
      end else begin
        grant0 = m0_arvalid;
        grant1 = m1_arvalid;
      end
    end
  end

  assign in_addr   = (state == ST_ADDR);
  assign in_data   = (state == ST_DATA);
  assign own0      = in_data && !owner;
  assign own1      = in_data &&  owner;
  assign beat_fire = in_data && s_rvalid && s_rready;

  // -------------------------------------------------------------------------
  // Sequencing FSM. Once a transaction starts, the only exit from DATA is an
  // accepted beat carrying s_rlast. An error response is just data here.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            owner  <= grant1;
            addr_q <= grant1 ? m1_araddr : m0_araddr;
            len_q  <= grant1 ? m1_arlen  : m0_arlen;
            state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // addr_q/len_q are frozen here, so s_araddr stays stable until
          // the slave accepts the request.
          if (s_arready) begin
            beat_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (s_rlast) begin
              last_owner <= owner;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request handshake back to the masters
  assign m0_arready = grant0;
  assign m1_arready = grant1;

  // Shared AR channel
  assign s_arvalid = in_addr;
  assign s_araddr  = addr_q;
  assign s_arlen   = len_q;
  assign s_arsize  = 3'b010;
  assign s_arburst = 2'b01;

  // -------------------------------------------------------------------------
  // R channel routing. The non-owner sees all-zero outputs. Outside DATA
  // both masters see zeros and the slave sees s_rready low. Any beat the
  // slave still presents after an aborted burst is therefore dropped.
  // -------------------------------------------------------------------------
  assign s_rready  = in_data && (owner ? m1_rready : m0_rready);

  assign m0_rvalid = own0 && s_rvalid;
  assign m0_rdata  = own0 ? s_rdata : '0;
  assign m0_rresp  = own0 ? s_rresp : 2'b00;
  assign m0_rlast  = own0 && s_rlast;

  assign m1_rvalid = own1 && s_rvalid;
  assign m1_rdata  = own1 ? s_rdata : '0;
  assign m1_rresp  = own1 ? s_rresp : 2'b00;
  assign m1_rlast  = own1 && s_rlast;

  assign busy      = in_addr || in_data;

endmodule

// File: doc/ysyx_20020207_axi_rd_arbiter.md
YSYX_20020207_AXI_RD_ARBITER -- requirements
Module: ysyx_20020207_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, read data width.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 SHALL have port m{0,1}_arvalid  in  1  read request; m0 = IFU/icache, m1 = LSU.
REQ-006 SHALL have port m{0,1}_arready  out  1  request accepted.
REQ-007 SHALL have port m{0,1}_araddr  in  ADDR_W  request address.
REQ-008 SHALL have port m{0,1}_arlen  in  8  burst length minus one.
REQ-009 SHALL have port m{0,1}_rvalid  out  1  read beat valid.
REQ-010 SHALL have port m{0,1}_rready  in  1  master accepts beat.
REQ-011 SHALL have port m{0,1}_rdata  out  DATA_W  beat data.
REQ-012 SHALL have port m{0,1}_rresp  out  2  beat response.
REQ-013 SHALL have port m{0,1}_rlast  out  1  final beat.
REQ-014 SHALL have ports s_arvalid out 1, s_arready in 1, s_araddr out ADDR_W, s_arlen out 8: shared memory AR channel.
REQ-015 SHALL have ports s_arsize out 3 (constant 3'b010) and s_arburst out 2 (constant 2'b01, INCR).
REQ-016 SHALL have ports s_rvalid in 1, s_rready out 1, s_rdata in DATA_W, s_rresp in 2, s_rlast in 1: shared R channel.
REQ-017 SHALL have port busy  out  1  high in ADDR or DATA state.

Function
REQ-018 SHALL implement FSM states IDLE, ADDR, DATA plus registers owner (1b), last_owner (1b), addr/len latches, beat counter (8b).
REQ-019 In IDLE with exactly one mX_arvalid high, SHALL assert that mX_arready combinationally the same cycle, latch araddr/arlen, set owner=X, go to ADDR.
REQ-020 In IDLE with both arvalid high, SHALL grant the master != last_owner (round robin); loser's arready stays 0.
REQ-021 SHALL never assert m0_arready and m1_arready together, and never assert either outside IDLE.
REQ-022 In ADDR SHALL drive s_arvalid=1 with latched address/length, held stable until s_arready; on s_arvalid&&s_arready go to DATA, clear beat counter.
REQ-023 In DATA SHALL route s_rvalid/s_rdata/s_rresp/s_rlast to owner and s_rready = owner's mX_rready; non-owner rvalid/rlast SHALL be 0, rdata/rresp 0.
REQ-024 Each s_rvalid&&s_rready beat in DATA SHALL increment the beat counter (wraps at 255, no saturation).
REQ-025 Beat with s_rlast=1 accepted SHALL return FSM to IDLE next cycle and set last_owner=owner; s_rlast alone terminates, counter is informational.
REQ-026 Non-OKAY rresp SHALL be forwarded unchanged and SHALL NOT alter sequencing.
REQ-027 Outside DATA SHALL hold s_rready=0 and all mX_rvalid=0; outside ADDR s_arvalid=0.
REQ-028 Request arrival in the same cycle as final beat SHALL wait; it is granted in the following IDLE cycle (minimum one IDLE cycle between transactions).
REQ-029 A master dropping arvalid before grant SHALL be ignored without state change.

Reset
REQ-030 On reset=0 SHALL asynchronously force IDLE, owner=0, last_owner=1 (m0 wins first tie), counter=0, latches=0.
REQ-031 During reset SHALL drive s_arvalid, s_rready, all mX_arready, mX_rvalid, mX_rlast, busy to 0; s_arsize/s_arburst stay constant.
REQ-032 Reset mid-burst SHALL abandon the transaction; after release FSM in IDLE accepts new requests, no residual beats routed.

Verification
REQ-033 m0 single read addr 0x8000_0000 arlen 0, s_arready after 2 cycles, one beat data 0x1234_5678 -> m0_arready same cycle as request, s_araddr 0x8000_0000, m0_rdata 0x1234_5678 rlast 1, busy low after.
REQ-034 Both arvalid in same IDLE cycle after reset -> m0 granted first; on next tie m1 granted; alternates thereafter.
REQ-035 m1 burst arlen 3, slave stalls rvalid and m1 stalls rready randomly -> exactly 4 beats to m1 in order, m0_rvalid never high, counter=4 at end.
REQ-036 m0 arvalid raised during m1 DATA -> m0_arready stays 0 until IDLE after m1 rlast, then granted; s_araddr switches only in ADDR.
REQ-037 Reset pulsed low in DATA after 2 of 4 beats -> all outputs 0 immediately; post-release m1 request completes normally.
REQ-038 Beat with rresp 2'b10 -> forwarded to owner unchanged, transaction completes on rlast.
